// File: rtl/lab_mem_arb.sv
// lab_mem_arb: two-requester arbiter sharing one single-port RAM between the CPU and a
// program loader/debug port. Each access is a three-cycle IDLE/ACCESS/RESP transaction
// that ends with a one-cycle ack to the winning requester.
//
// Optional feature: define LAB_ARB_BURST_LIMIT_EN to cap consecutive locked loader grants
// at BURST_MAX while the CPU is waiting. Without it, ld_lock can hold off the CPU forever.
//
// Ports:
//   clock, reset            single rising-edge clock, synchronous active-low reset
//   cpu_req/wr/addr/wdata   CPU request (level) and access fields; cpu_ack completion pulse
//   ld_req/wr/addr/wdata    loader request (level) and access fields; ld_ack completion pulse
//   ld_lock                 loader bus-lock: loader wins ties
//   rdata                   read data, non-zero only while an ack is high on a read
//   mem_en/wr/addr/wdata    RAM command, driven only in ACCESS
//   mem_rdata               RAM read data, registered by the RAM one cycle after mem_en
//   busy                    high in ACCESS and RESP
//   owner                   current or last owner (0 = CPU, 1 = loader)
module lab_mem_arb #(
   parameter int unsigned AW        = 5,
   parameter int unsigned DW        = 8,
   parameter int unsigned BURST_MAX = 4
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          cpu_req,
   input  logic          cpu_wr,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_ack,
   input  logic          ld_req,
   input  logic          ld_wr,
   input  logic [AW-1:0] ld_addr,
   input  logic [DW-1:0] ld_wdata,
   input  logic          ld_lock,
   output logic          ld_ack,
   output logic [DW-1:0] rdata,
   output logic          mem_en,
   output logic          mem_wr,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy,
   output logic          owner
);

   typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

   state_e state_q, state_d;
   logic   owner_q, owner_d;
   // Last completed owner; resets to the loader so the CPU wins the first tie.
   logic   last_q, last_d;

   logic          any_req;
   logic          both_req;
   logic          win_ld;
   logic          burst_hit;
   logic          sel_wr;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;

   assign any_req  = cpu_req | ld_req;
   assign both_req = cpu_req & ld_req;

`ifdef LAB_ARB_BURST_LIMIT_EN
   localparam logic [2:0] BurstMax = 3'(BURST_MAX);

   logic [2:0] burst_q, burst_d;

   assign burst_hit = cpu_req && (burst_q == BurstMax);

   always_comb begin
      burst_d = burst_q;
      if (!cpu_req) begin
         burst_d = 3'd0;
      end else if (state_q == StIdle && any_req) begin
         if (!win_ld) begin
            burst_d = 3'd0;
         end else if (both_req && ld_lock && burst_q != 3'd7) begin
            burst_d = burst_q + 3'd1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         burst_q <= 3'd0;
      end else begin
         burst_q <= burst_d;
      end
   end
`else
   assign burst_hit = 1'b0;
`endif

   // Winner selection, only acted upon in IDLE.
   always_comb begin
      win_ld = 1'b0;
      if (ld_req && !cpu_req) begin
         win_ld = 1'b1;
      end else if (both_req) begin
         if (ld_lock) begin
            win_ld = !burst_hit;
         end else begin
            win_ld = !last_q;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      unique case (state_q)
         StIdle: begin
            if (any_req) begin
               owner_d = win_ld;
               state_d = StAccess;
            end
         end
         StAccess: state_d = StResp;
         StResp: begin
            last_d  = owner_q;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= StIdle;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
      end
   end

   // Owner's access fields; requesters hold them stable until their ack.
   assign sel_wr    = owner_q ? ld_wr    : cpu_wr;
   assign sel_addr  = owner_q ? ld_addr  : cpu_addr;
   assign sel_wdata = owner_q ? ld_wdata : cpu_wdata;

   always_comb begin
      mem_en    = 1'b0;
      mem_wr    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      cpu_ack   = 1'b0;
      ld_ack    = 1'b0;
      rdata     = '0;
      if (state_q == StAccess) begin
         mem_en    = 1'b1;
         mem_wr    = sel_wr;
         mem_addr  = sel_addr;
         mem_wdata = sel_wdata;
      end
      if (state_q == StResp) begin
         cpu_ack = !owner_q;
         ld_ack  = owner_q;
         if (!sel_wr) begin
            rdata = mem_rdata;
         end
      end
   end

   assign busy  = (state_q != StIdle);
   assign owner = owner_q;

endmodule

// File: tb/tb_lab_mem_arb.sv
module tb_lab_mem_arb;

   logic       clock = 1'b0;
   logic       reset;
   logic       cpu_req, cpu_wr, cpu_ack;
   logic [4:0] cpu_addr;
   logic [7:0] cpu_wdata;
   logic       ld_req, ld_wr, ld_lock, ld_ack;
   logic [4:0] ld_addr;
   logic [7:0] ld_wdata;
   logic [7:0] rdata;
   logic       mem_en, mem_wr;
   logic [4:0] mem_addr;
   logic [7:0] mem_wdata, mem_rdata;
   logic       busy, owner;

   int checks = 0;
   int errors = 0;
   int cpu_ack_cnt = 0;
   int ld_ack_cnt = 0;
   int both_ack_cnt = 0;
   int mem_wr_cnt = 0;

   logic [7:0] ram [32];

   always #5 clock = ~clock;

   lab_mem_arb #(.AW(5), .DW(8), .BURST_MAX(4)) dut (
      .clock     (clock),
      .reset     (reset),
      .cpu_req   (cpu_req),
      .cpu_wr    (cpu_wr),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_ack   (cpu_ack),
      .ld_req    (ld_req),
      .ld_wr     (ld_wr),
      .ld_addr   (ld_addr),
      .ld_wdata  (ld_wdata),
      .ld_lock   (ld_lock),
      .ld_ack    (ld_ack),
      .rdata     (rdata),
      .mem_en    (mem_en),
      .mem_wr    (mem_wr),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .busy      (busy),
      .owner     (owner)
   );

   // Single-port RAM with registered read data (read-before-write).
   always @(posedge clock) begin
      if (mem_en) begin
         mem_rdata <= ram[mem_addr];
         if (mem_wr) ram[mem_addr] = mem_wdata;
      end
   end

   always @(negedge clock) begin
      if (cpu_ack) cpu_ack_cnt++;
      if (ld_ack) ld_ack_cnt++;
      if (cpu_ack && ld_ack) both_ack_cnt++;
      if (mem_wr) mem_wr_cnt++;
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      cpu_req = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0;
      ld_req = 0; ld_wr = 0; ld_addr = '0; ld_wdata = '0; ld_lock = 0;
   endtask

   task automatic apply_reset();
      idle_inputs();
      reset = 0;
      step();
      step();
      reset = 1;
   endtask

   task automatic test_reset();
      reset = 0;
      cpu_req = 1; cpu_wr = 1; cpu_addr = 5'h07; cpu_wdata = 8'h55;
      ld_req = 1; ld_wr = 1; ld_addr = 5'h09; ld_wdata = 8'h66;
      step();
      step();
      checks++;
      if ({cpu_ack, ld_ack, mem_en, mem_wr, busy, owner} !== 6'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b required 000000",
                  {cpu_ack, ld_ack, mem_en, mem_wr, busy, owner});
      end
      checks++;
      if ({mem_addr, mem_wdata, rdata} !== 21'h0) begin
         errors++;
         $display("FAIL reset_data: got addr %h wdata %h rdata %h required 0",
                  mem_addr, mem_wdata, rdata);
      end
      idle_inputs();
      reset = 1;
      step();
   endtask

   task automatic test_cpu_read();
      cpu_req = 1; cpu_wr = 0; cpu_addr = 5'h03;
      step();
      checks++;
      if ({mem_en, mem_wr, busy, cpu_ack} !== 4'b1010) begin
         errors++;
         $display("FAIL rd_access: got en/wr/busy/ack %b required 1010",
                  {mem_en, mem_wr, busy, cpu_ack});
      end
      checks++;
      if (mem_addr !== 5'h03) begin
         errors++;
         $display("FAIL rd_addr: got %h required 03", mem_addr);
      end
      step();
      checks++;
      if ({cpu_ack, ld_ack, mem_en, owner} !== 4'b1000) begin
         errors++;
         $display("FAIL rd_resp: got ack/ldack/en/owner %b required 1000",
                  {cpu_ack, ld_ack, mem_en, owner});
      end
      checks++;
      if (rdata !== 8'hA5) begin
         errors++;
         $display("FAIL rd_data: got %h required a5", rdata);
      end
      cpu_req = 0;
      step();
      checks++;
      if ({busy, cpu_ack, mem_en} !== 3'b000) begin
         errors++;
         $display("FAIL rd_idle: got busy/ack/en %b required 000", {busy, cpu_ack, mem_en});
      end
   endtask

   task automatic test_ld_write_cpu_read();
      int c0, l0;
      bit seen;
      c0 = cpu_ack_cnt;
      l0 = ld_ack_cnt;
      ld_req = 1; ld_wr = 1; ld_addr = 5'h10; ld_wdata = 8'h3C;
      seen = 0;
      for (int i = 0; i < 8 && !seen; i++) begin
         step();
         if (ld_ack) begin
            seen = 1;
            checks++;
            if ({owner, rdata} !== 9'h100) begin
               errors++;
               $display("FAIL ldwr_ack: got owner %b rdata %h required 1 00", owner, rdata);
            end
         end
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL ldwr_timeout: got no ld_ack required one within 8 cycles");
      end
      idle_inputs();
      step();
      cpu_req = 1; cpu_wr = 0; cpu_addr = 5'h10;
      seen = 0;
      for (int i = 0; i < 8 && !seen; i++) begin
         step();
         if (cpu_ack) begin
            seen = 1;
            checks++;
            if (rdata !== 8'h3C) begin
               errors++;
               $display("FAIL ldwr_cpurd: got %h required 3c", rdata);
            end
         end
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL cpurd_timeout: got no cpu_ack required one within 8 cycles");
      end
      idle_inputs();
      step();
      step();
      checks++;
      if ((cpu_ack_cnt - c0) !== 1 || (ld_ack_cnt - l0) !== 1) begin
         errors++;
         $display("FAIL ldwr_ackcnt: got cpu %0d ld %0d required 1 1",
                  cpu_ack_cnt - c0, ld_ack_cnt - l0);
      end
   endtask

   task automatic test_round_robin();
      int n;
      int last_step;
      apply_reset();
      cpu_req = 1; cpu_wr = 0; cpu_addr = 5'h03;
      ld_req = 1; ld_wr = 0; ld_addr = 5'h10; ld_lock = 0;
      n = 0;
      last_step = -1;
      for (int i = 1; i <= 20 && n < 4; i++) begin
         step();
         if (cpu_ack || ld_ack) begin
            checks++;
            if (ld_ack !== n[0] || cpu_ack !== !n[0]) begin
               errors++;
               $display("FAIL rr_order%0d: got cpu %b ld %b required ld=%b", n, cpu_ack,
                        ld_ack, n[0]);
            end
            checks++;
            if (i !== 2 + 3 * n) begin
               errors++;
               $display("FAIL rr_time%0d: got cycle %0d required %0d", n, i, 2 + 3 * n);
            end
            checks++;
            if (rdata !== (n[0] ? 8'h3C : 8'hA5)) begin
               errors++;
               $display("FAIL rr_data%0d: got %h required %h", n, rdata,
                        n[0] ? 8'h3C : 8'hA5);
            end
            n++;
         end
      end
      checks++;
      if (n !== 4) begin
         errors++;
         $display("FAIL rr_count: got %0d acks required 4", n);
      end
      idle_inputs();
      step();
   endtask

   task automatic test_lock();
      bit seq [16];
      int n, nc, nl;
      apply_reset();
      cpu_req = 1; cpu_wr = 0; cpu_addr = 5'h03;
      ld_req = 1; ld_wr = 0; ld_addr = 5'h10; ld_lock = 1;
      n = 0; nc = 0; nl = 0;
      for (int i = 1; i <= 40; i++) begin
         step();
         if (cpu_ack) nc++;
         if (ld_ack) nl++;
         if ((cpu_ack || ld_ack) && n < 16) begin
            seq[n] = ld_ack;
            n++;
         end
      end
`ifdef LAB_ARB_BURST_LIMIT_EN
      for (int k = 0; k < 10; k++) begin
         checks++;
         if (k >= n || seq[k] !== ((k % 5) != 4)) begin
            errors++;
            $display("FAIL lock_burst%0d: got ld=%b required ld=%b", k, (k < n) ? seq[k] : 1'b0,
                     (k % 5) != 4);
         end
      end
`else
      checks++;
      if (nc !== 0) begin
         errors++;
         $display("FAIL lock_starve_cpu: got %0d cpu acks required 0", nc);
      end
      checks++;
      if (nl !== 13) begin
         errors++;
         $display("FAIL lock_starve_ld: got %0d loader acks required 13", nl);
      end
`endif
      idle_inputs();
      step();
      step();
   endtask

   task automatic test_reset_abort();
      int l0;
      bit seen;
      apply_reset();
      step();
      l0 = ld_ack_cnt;
      ld_req = 1; ld_wr = 0; ld_addr = 5'h10;
      step();
      checks++;
      if ({mem_en, owner} !== 2'b11) begin
         errors++;
         $display("FAIL abort_access: got en/owner %b required 11", {mem_en, owner});
      end
      reset = 0;
      step();
      checks++;
      if ({ld_ack, cpu_ack, mem_en, busy, owner, rdata, mem_addr} !== 18'h0) begin
         errors++;
         $display("FAIL abort_outputs: got ack %b en %b busy %b owner %b rdata %h addr %h required 0",
                  ld_ack, mem_en, busy, owner, rdata, mem_addr);
      end
      reset = 1;
      seen = 0;
      for (int i = 1; i <= 6 && !seen; i++) begin
         step();
         if (ld_ack) begin
            seen = 1;
            checks++;
            if (i !== 2 || rdata !== 8'h3C) begin
               errors++;
               $display("FAIL abort_retry: got cycle %0d rdata %h required 2 3c", i, rdata);
            end
         end
      end
      idle_inputs();
      step();
      checks++;
      if ((ld_ack_cnt - l0) !== 1) begin
         errors++;
         $display("FAIL abort_ackcnt: got %0d loader acks required 1", ld_ack_cnt - l0);
      end
   endtask

   task automatic test_cpu_write();
      int w0;
      w0 = mem_wr_cnt;
      cpu_req = 1; cpu_wr = 1; cpu_addr = 5'h1F; cpu_wdata = 8'hFF;
      step();
      checks++;
      if ({mem_en, mem_wr, mem_addr, mem_wdata} !== {2'b11, 5'h1F, 8'hFF}) begin
         errors++;
         $display("FAIL wr_access: got en %b wr %b addr %h wdata %h required 1 1 1f ff",
                  mem_en, mem_wr, mem_addr, mem_wdata);
      end
      step();
      checks++;
      if ({cpu_ack, mem_wr, rdata} !== {2'b10, 8'h00}) begin
         errors++;
         $display("FAIL wr_resp: got ack %b wr %b rdata %h required 1 0 00",
                  cpu_ack, mem_wr, rdata);
      end
      idle_inputs();
      step();
      checks++;
      if ((mem_wr_cnt - w0) !== 1 || ram[31] !== 8'hFF) begin
         errors++;
         $display("FAIL wr_effect: got %0d wr cycles ram %h required 1 ff",
                  mem_wr_cnt - w0, ram[31]);
      end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) ram[i] = 8'h00;
      ram[3]  = 8'hA5;
      ram[31] = 8'h11;
      idle_inputs();
      reset = 0;
      test_reset();
      test_cpu_read();
      test_ld_write_cpu_read();
      test_round_robin();
      test_lock();
      test_reset_abort();
      test_cpu_write();
      checks++;
      if (both_ack_cnt !== 0) begin
         errors++;
         $display("FAIL ack_exclusive: got %0d overlapping acks required 0", both_ack_cnt);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
